// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input and baud divider.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(DATA_BITS + 1);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic       ODD    = (PARITY_ODD != 0);
`endif

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
    $error("uart_tx_param: illegal parameter value");
  end

  logic [2:0]           state;
  logic [BW-1:0]        baud;
  logic [CW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
`ifdef UART_TX_PARITY_EN
  logic [DATA_BITS-1:0] word;
`endif

  logic accept;
  logic tick;

  assign accept   = tx_valid && tx_ready;
  assign tick     = (baud == BAUD_LAST);
  assign tx_ready = (state == IDLE) && !rst;
  assign tx_busy  = (state != IDLE);
  assign tx_done  = (state == STOP) && tick && (bit_cnt == STOP_LAST);

  // txd is loaded with the next slot's level on the same edge as the state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      word    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          baud    <= '0;
          bit_cnt <= '0;
          if (accept) begin
            shift <= tx_data;
`ifdef UART_TX_PARITY_EN
            word  <= tx_data;
`endif
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            baud  <= '0;
            txd   <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            baud  <= '0;
            shift <= shift >> 1;
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              txd   <= ^word ^ ODD;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              txd     <= shift[1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            baud  <= '0;
            txd   <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          txd <= 1'b1;
          if (tick) begin
            baud <= '0;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frames, back-to-back, reset abort,
// narrow word with two stop bits, and data changing after accept.
module tb_uart_tx_param;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int S1 = 10 + PB;
  localparam int F1 = S1 * CPB;
  localparam int S5 = 8 + PB;
  localparam int F5 = S5 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       v8 = 1'b0;
  logic [7:0] d8 = 8'h00;
  logic       r8, txd8, busy8, done8;
  logic       v5 = 1'b0;
  logic [4:0] d5 = 5'h00;
  logic       r5, txd5, busy5, done5;

  int total = 0;
  int bad   = 0;

  bit t_txd [256];
  bit t_done[256];
  bit t_rdy [256];
  bit t_busy[256];

`ifdef UART_TX_PARITY_EN
  bit e1[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  bit e5[9]  = '{0, 1, 1, 0, 0, 1, 0, 1, 1};
`else
  bit e1[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  bit e5[8]  = '{0, 1, 1, 0, 0, 1, 1, 1};
`endif

  always #5 clk = ~clk;

  uart_tx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)
  ) u_dut (
    .clk(clk), .rst(rst), .tx_valid(v8), .tx_ready(r8), .tx_data(d8),
    .txd(txd8), .tx_busy(busy8), .tx_done(done8)
  );

  uart_tx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(1)
  ) u_dut5 (
    .clk(clk), .rst(rst), .tx_valid(v5), .tx_ready(r5), .tx_data(d5),
    .txd(txd5), .tx_busy(busy5), .tx_done(done5)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic record(input int base, input int n, input bit sel,
                        input bit scramble);
    for (int i = 0; i < n; i++) begin
      t_txd[base+i]  = sel ? txd5  : txd8;
      t_done[base+i] = sel ? done5 : done8;
      t_rdy[base+i]  = sel ? r5    : r8;
      t_busy[base+i] = sel ? busy5 : busy8;
      @(posedge clk);
      #1;
      if (scramble) d8 = 8'((base + i) * 37 + 11);
    end
  endtask

  function automatic bit model(input int word, input int nb,
                               input int odd, input int s);
    int m;
    m = (1 << nb) - 1;
    if (s == 0) return 1'b0;
    if (s <= nb) return word[s-1];
    if (PB == 1 && s == nb + 1) return (^(word & m)) ^ odd[0];
    return 1'b1;
  endfunction

  function automatic logic [3:0] nib(input int b);
    return {t_txd[b], t_txd[b+1], t_txd[b+2], t_txd[b+3]};
  endfunction

  task automatic chk_slots(input string tag, input int base, input int ns,
                           input int word, input int nb, input int odd);
    for (int s = 0; s < ns; s++)
      chk($sformatf("%s_slot%0d", tag, s), 32'(nib(base + s * CPB)),
          model(word, nb, odd, s) ? 32'hF : 32'h0);
  endtask

  task automatic chk_frame(input string tag, input int base, input int len);
    int first, nd, nb, nr;
    first = -1; nd = 0; nb = 0; nr = 0;
    for (int i = base; i < base + len; i++) begin
      if (t_done[i]) begin
        nd++;
        if (first < 0) first = i - base;
      end
      if (t_busy[i]) nb++;
      if (t_rdy[i]) nr++;
    end
    chk({tag, "_done_at"}, 32'(first), 32'(len - 1));
    chk({tag, "_done_cnt"}, 32'(nd), 32'd1);
    chk({tag, "_busy_cyc"}, 32'(nb), 32'(len));
    chk({tag, "_ready_cyc"}, 32'(nr), 32'd0);
    chk({tag, "_ready_after"}, 32'(t_rdy[base+len]), 32'd1);
    chk({tag, "_idle_after"}, 32'(t_txd[base+len]), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_txd", 32'(txd8), 32'd1);
    chk("rst_ready", 32'(r8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(r8), 32'd1);
    chk("idle_txd", 32'(txd8), 32'd1);

    // single word, data changed right after accept
    d8 = 8'hA5; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0; d8 = 8'h00;
    chk("t1_start_lat", 32'(txd8), 32'd0);
    record(0, F1 + 1, 1'b0, 1'b0);
    for (int s = 0; s < S1; s++)
      chk($sformatf("t1_slot%0d", s), 32'(nib(s * CPB)),
          e1[s] ? 32'hF : 32'h0);
    chk_frame("t1", 0, F1);

    // back-to-back with valid held high
    d8 = 8'h00; v8 = 1'b1;
    @(posedge clk); #1;
    d8 = 8'hFF;
    record(0, F1 + 5, 1'b0, 1'b0);
    v8 = 1'b0;
    record(F1 + 5, F1 - 3, 1'b0, 1'b0);
    chk_slots("t3a", 0, S1, 8'h00, 8, 0);
    chk("t3_gap_txd", 32'(t_txd[F1]), 32'd1);
    chk("t3_gap_ready", 32'(t_rdy[F1]), 32'd1);
    chk("t3_gap_busy", 32'(t_busy[F1]), 32'd0);
    chk_slots("t3b", F1 + 1, S1, 8'hFF, 8, 0);
    chk_frame("t3b", F1 + 1, F1);
    nd = 0;
    for (int i = 0; i < 2 * F1 + 2; i++) if (t_done[i]) nd++;
    chk("t3_done_total", 32'(nd), 32'd2);

    // reset in cycle 15 of a frame
    d8 = 8'h3B; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    record(0, 14, 1'b0, 1'b0);
    chk("t4_pre_txd", 32'(txd8), 32'd0);
    rst = 1'b1;
    #1;
    chk("t4_rst_txd", 32'(txd8), 32'd1);
    chk("t4_rst_busy", 32'(busy8), 32'd0);
    chk("t4_rst_done", 32'(done8), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t4_rel_ready", 32'(r8), 32'd1);
    d8 = 8'hC3; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    record(0, F1 + 1, 1'b0, 1'b0);
    chk_slots("t4", 0, S1, 8'hC3, 8, 0);
    chk_frame("t4", 0, F1);

    // tx_data toggling every cycle during the frame
    d8 = 8'h5A; v8 = 1'b1;
    @(posedge clk); #1;
    v8 = 1'b0;
    record(0, F1 + 1, 1'b0, 1'b1);
    chk_slots("t6", 0, S1, 8'h5A, 8, 0);
    chk_frame("t6", 0, F1);

    // 5 data bits, 2 stop bits, odd parity when enabled
    d5 = 5'h13; v5 = 1'b1;
    @(posedge clk); #1;
    v5 = 1'b0;
    record(0, F5 + 1, 1'b1, 1'b0);
    for (int s = 0; s < S5; s++)
      chk($sformatf("t5_slot%0d", s), 32'(nib(s * CPB)),
          e5[s] ? 32'hF : 32'h0);
    chk_frame("t5", 0, F5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
